// File: rtl/hostmem_pkg.sv
// Shared encodings for the host memory writer: target select codes,
// decode states and default memory address widths.
package hostmem_pkg;

  localparam int DEF_CHROW_AW = 8;
  localparam int DEF_PAL_AW   = 8;
  localparam int DEF_FONT_AW  = 12;

  localparam logic [1:0] TGT_CHROW = 2'b00;
  localparam logic [1:0] TGT_PAL   = 2'b01;
  localparam logic [1:0] TGT_FONT  = 2'b10;
  localparam logic [1:0] TGT_RSVD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ADDR_LO = 3'd1,
    ADDR_HI = 3'd2,
    DATA_LO = 3'd3,
    DATA_HI = 3'd4
  } state_t;

endpackage

// File: rtl/host_port_sync.sv
// Brings the asynchronous host port into the clk domain and emits a one-cycle
// byte_valid pulse on each synchronised rising edge of host_nwr.
module host_port_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [7:0] host_d,
  input  logic       host_rs,
  input  logic       host_nwr,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_rs
);

  logic [SYNC_STAGES-1:0]      nwr_sync_q, nwr_sync_d;
  logic [SYNC_STAGES-1:0]      rs_sync_q, rs_sync_d;
  logic [SYNC_STAGES-1:0][7:0] d_sync_q, d_sync_d;
  logic                        nwr_prev_q, nwr_prev_d;
  logic                        rs_prev_q, rs_prev_d;
  logic [7:0]                  d_prev_q, d_prev_d;

  always_comb begin
    nwr_sync_d = {nwr_sync_q[SYNC_STAGES-2:0], host_nwr};
    rs_sync_d  = {rs_sync_q[SYNC_STAGES-2:0], host_rs};
    d_sync_d   = {d_sync_q[SYNC_STAGES-2:0], host_d};
    nwr_prev_d = nwr_sync_q[SYNC_STAGES-1];
    rs_prev_d  = rs_sync_q[SYNC_STAGES-1];
    d_prev_d   = d_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      nwr_sync_q <= '1;
      rs_sync_q  <= '0;
      d_sync_q   <= '0;
      nwr_prev_q <= 1'b1;
      rs_prev_q  <= 1'b0;
      d_prev_q   <= '0;
    end else begin
      nwr_sync_q <= nwr_sync_d;
      rs_sync_q  <= rs_sync_d;
      d_sync_q   <= d_sync_d;
      nwr_prev_q <= nwr_prev_d;
      rs_prev_q  <= rs_prev_d;
      d_prev_q   <= d_prev_d;
    end
  end

  // The byte and rs are taken one cycle behind the edge so they were sampled
  // while the strobe was still low and the host guaranteed them stable.
  assign byte_valid = nwr_sync_q[SYNC_STAGES-1] & ~nwr_prev_q;
  assign byte_data  = d_prev_q;
  assign byte_rs    = rs_prev_q;

endmodule

// File: rtl/host_mem_writer.sv
// Decodes the synchronised host byte stream (command / address / data) and
// drives single-cycle active-low write strobes into chrowbuf, palette and fontmem.
module host_mem_writer
  import hostmem_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CHROW_AW    = DEF_CHROW_AW,
  parameter int PAL_AW      = DEF_PAL_AW,
  parameter int FONT_AW     = DEF_FONT_AW
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic [7:0]          host_d,
  input  logic                host_rs,
  input  logic                host_nwr,
  output logic                chrowbuf_wr,
  output logic [CHROW_AW-1:0] chrowbuf_wr_addr,
  output logic [15:0]         chrowbuf_wr_data,
  output logic                palette_wr,
  output logic [PAL_AW-1:0]   palette_wr_addr,
  output logic [15:0]         palette_wr_data,
  output logic                fontmem_wr,
  output logic [FONT_AW-1:0]  fontmem_wr_addr,
  output logic [7:0]          fontmem_wr_data,
  output logic                host_err
);

  logic       byte_valid, byte_rs;
  logic [7:0] byte_data;

  host_port_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .nrst       (nrst),
    .host_d     (host_d),
    .host_rs    (host_rs),
    .host_nwr   (host_nwr),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_rs    (byte_rs)
  );

  state_t              state_q, state_d;
  logic [1:0]          tgt_q, tgt_d;
  logic [15:0]         addr_q, addr_d;
  logic [7:0]          lo_q, lo_d;
  logic                err_q, err_d;
  logic                chrow_wr_q, chrow_wr_d;
  logic [CHROW_AW-1:0] chrow_addr_q, chrow_addr_d;
  logic [15:0]         chrow_data_q, chrow_data_d;
  logic                pal_wr_q, pal_wr_d;
  logic [PAL_AW-1:0]   pal_addr_q, pal_addr_d;
  logic [15:0]         pal_data_q, pal_data_d;
  logic                font_wr_q, font_wr_d;
  logic [FONT_AW-1:0]  font_addr_q, font_addr_d;
  logic [7:0]          font_data_q, font_data_d;
  logic                issue;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q      <= IDLE;
      tgt_q        <= TGT_CHROW;
      addr_q       <= '0;
      lo_q         <= '0;
      err_q        <= 1'b0;
      chrow_wr_q   <= 1'b1;
      chrow_addr_q <= '0;
      chrow_data_q <= '0;
      pal_wr_q     <= 1'b1;
      pal_addr_q   <= '0;
      pal_data_q   <= '0;
      font_wr_q    <= 1'b1;
      font_addr_q  <= '0;
      font_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      addr_q       <= addr_d;
      lo_q         <= lo_d;
      err_q        <= err_d;
      chrow_wr_q   <= chrow_wr_d;
      chrow_addr_q <= chrow_addr_d;
      chrow_data_q <= chrow_data_d;
      pal_wr_q     <= pal_wr_d;
      pal_addr_q   <= pal_addr_d;
      pal_data_q   <= pal_data_d;
      font_wr_q    <= font_wr_d;
      font_addr_q  <= font_addr_d;
      font_data_q  <= font_data_d;
    end
  end

  // Address is kept 16 bits wide; wrapping modulo 2^AW falls out of slicing
  // the low AW bits at the memory port.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    err_d   = err_q;
    if (byte_valid) begin
      if (!byte_rs) begin
        tgt_d  = byte_data[7:6];
        addr_d = '0;
        lo_d   = '0;
        if (byte_data[7:6] == TGT_RSVD) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = ADDR_LO;
        end
      end else begin
        case (state_q)
          IDLE: err_d = 1'b1;
          ADDR_LO: begin
            addr_d[7:0] = byte_data;
            state_d     = ADDR_HI;
          end
          ADDR_HI: begin
            addr_d[15:8] = byte_data;
            state_d      = DATA_LO;
          end
          DATA_LO: begin
            if (tgt_q == TGT_FONT) begin
              addr_d = addr_q + 16'd1;
            end else begin
              lo_d    = byte_data;
              state_d = DATA_HI;
            end
          end
          DATA_HI: begin
            addr_d  = addr_q + 16'd1;
            state_d = DATA_LO;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign issue = byte_valid & byte_rs &
                 (((state_q == DATA_LO) && (tgt_q == TGT_FONT)) || (state_q == DATA_HI));

  always_comb begin
    chrow_wr_d   = 1'b1;
    chrow_addr_d = chrow_addr_q;
    chrow_data_d = chrow_data_q;
    pal_wr_d     = 1'b1;
    pal_addr_d   = pal_addr_q;
    pal_data_d   = pal_data_q;
    font_wr_d    = 1'b1;
    font_addr_d  = font_addr_q;
    font_data_d  = font_data_q;
    if (issue) begin
      case (tgt_q)
        TGT_CHROW: begin
          chrow_wr_d   = 1'b0;
          chrow_addr_d = addr_q[CHROW_AW-1:0];
          chrow_data_d = {byte_data, lo_q};
        end
        TGT_PAL: begin
          pal_wr_d   = 1'b0;
          pal_addr_d = addr_q[PAL_AW-1:0];
          pal_data_d = {byte_data, lo_q};
        end
        TGT_FONT: begin
          font_wr_d   = 1'b0;
          font_addr_d = addr_q[FONT_AW-1:0];
          font_data_d = byte_data;
        end
        default: ;
      endcase
    end
  end

  assign chrowbuf_wr      = chrow_wr_q;
  assign chrowbuf_wr_addr = chrow_addr_q;
  assign chrowbuf_wr_data = chrow_data_q;
  assign palette_wr       = pal_wr_q;
  assign palette_wr_addr  = pal_addr_q;
  assign palette_wr_data  = pal_data_q;
  assign fontmem_wr       = font_wr_q;
  assign fontmem_wr_addr  = font_addr_q;
  assign fontmem_wr_data  = font_data_q;
  assign host_err         = err_q;

endmodule

// File: tb/tb_host_mem_writer.sv
// Bench for host_mem_writer: host byte driver, byte-stream reference model,
// strobe monitor with expected-write queue, directed plus random sequences.
`timescale 1ns/1ps
module tb_host_mem_writer;
  import hostmem_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int CHROW_AW    = 8;
  localparam int PAL_AW      = 8;
  localparam int FONT_AW     = 12;
  localparam int W           = 66;

  logic                clk = 1'b0;
  logic                nrst = 1'b0;
  logic [7:0]          host_d = 8'h00;
  logic                host_rs = 1'b0;
  logic                host_nwr = 1'b1;
  logic                chrowbuf_wr, palette_wr, fontmem_wr, host_err;
  logic [CHROW_AW-1:0] chrowbuf_wr_addr;
  logic [15:0]         chrowbuf_wr_data;
  logic [PAL_AW-1:0]   palette_wr_addr;
  logic [15:0]         palette_wr_data;
  logic [FONT_AW-1:0]  fontmem_wr_addr;
  logic [7:0]          fontmem_wr_data;

  host_mem_writer #(
    .SYNC_STAGES(SYNC_STAGES), .CHROW_AW(CHROW_AW), .PAL_AW(PAL_AW), .FONT_AW(FONT_AW)
  ) dut (
    .clk(clk), .nrst(nrst), .host_d(host_d), .host_rs(host_rs), .host_nwr(host_nwr),
    .chrowbuf_wr(chrowbuf_wr), .chrowbuf_wr_addr(chrowbuf_wr_addr),
    .chrowbuf_wr_data(chrowbuf_wr_data),
    .palette_wr(palette_wr), .palette_wr_addr(palette_wr_addr),
    .palette_wr_data(palette_wr_data),
    .fontmem_wr(fontmem_wr), .fontmem_wr_addr(fontmem_wr_addr),
    .fontmem_wr_data(fontmem_wr_data),
    .host_err(host_err)
  );

  // ---------------- clock / reset ----------------
  always #12.5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           wr_count = 0;
  logic [1:0]   last_tgt;
  logic [15:0]  last_addr, last_data;

  // reference model: position in the byte stream since the last command
  bit         m_active = 0;
  bit         m_err    = 0;
  logic [1:0] m_tgt    = 2'b00;
  int         m_n      = 0;
  int         m_addr   = 0;
  logic [7:0] m_lo     = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int aw_of(input logic [1:0] t);
    if (t == TGT_FONT) return FONT_AW;
    if (t == TGT_PAL) return PAL_AW;
    return CHROW_AW;
  endfunction

  function automatic state_t model_state();
    if (!m_active) return IDLE;
    if (m_n == 0) return ADDR_LO;
    if (m_n == 1) return ADDR_HI;
    if (m_tgt == TGT_FONT) return DATA_LO;
    return ((m_n - 2) % 2 == 1) ? DATA_HI : DATA_LO;
  endfunction

  task automatic model_byte(input bit rs, input logic [7:0] d, input int rise_cyc);
    int k, a;
    logic [15:0] word;
    if (!rs) begin
      if (d[7:6] == 2'b11) begin
        m_active = 0;
        m_err    = 1;
      end else begin
        m_active = 1;
        m_tgt    = d[7:6];
        m_n      = 0;
        m_addr   = 0;
      end
    end else if (!m_active) begin
      m_err = 1;
    end else begin
      if (m_n == 0) m_addr = int'(d);
      else if (m_n == 1) m_addr = m_addr + int'(d) * 256;
      else begin
        k = m_n - 2;
        if (m_tgt == TGT_FONT) begin
          a = (m_addr + k) % (1 << aw_of(m_tgt));
          exp_q.push_back({m_tgt, 16'(a), 8'h00, d, 32'(rise_cyc + SYNC_STAGES + 1)});
        end else if (k % 2 == 1) begin
          a    = (m_addr + k / 2) % (1 << aw_of(m_tgt));
          word = {d, m_lo};
          exp_q.push_back({m_tgt, 16'(a), word, 32'(rise_cyc + SYNC_STAGES + 1)});
        end else begin
          m_lo = d;
        end
      end
      m_n++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic host_write(input bit rs, input logic [7:0] d);
    @(posedge clk); #2;
    host_d   = d;
    host_rs  = rs;
    host_nwr = 1'b0;
    repeat ($urandom_range(3, 5)) @(posedge clk);
    #2;
    host_nwr = 1'b1;
    model_byte(rs, d, cyc);
    repeat ($urandom_range(3, 5)) @(posedge clk);
  endtask

  task automatic do_reset(input int n, input bit toggle);
    @(posedge clk); #2;
    nrst = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #2;
      if (toggle && i < n - 1) host_nwr = ~host_nwr;
      else host_nwr = 1'b1;
    end
    nrst     = 1'b1;
    m_active = 0;
    m_err    = 0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  task automatic check_model(input string name);
    check({name, " state"}, 32'(dut.state_q), 32'(model_state()));
    check({name, " host_err"}, 32'(host_err), 32'(m_err));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    logic [W-1:0] act;
    logic [W-1:0] expv;
    int lows;
    lows = int'(!chrowbuf_wr) + int'(!palette_wr) + int'(!fontmem_wr);
    if (lows > 0) begin
      if (!chrowbuf_wr)
        act = {TGT_CHROW, 16'(chrowbuf_wr_addr), chrowbuf_wr_data, 32'(cyc)};
      else if (!palette_wr)
        act = {TGT_PAL, 16'(palette_wr_addr), palette_wr_data, 32'(cyc)};
      else
        act = {TGT_FONT, 16'(fontmem_wr_addr), 8'h00, fontmem_wr_data, 32'(cyc)};
      n_checks++;
      if (lows > 1 || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL write strobe: got tgt=%0d addr=0x%0h data=0x%0h cyc=%0d lows=%0d, expected no strobe",
                 act[65:64], act[63:48], act[47:32], act[31:0], lows);
      end else begin
        expv = exp_q.pop_front();
        if (act !== expv) begin
          n_fail++;
          $display("FAIL write: got tgt=%0d addr=0x%0h data=0x%0h cyc=%0d expected tgt=%0d addr=0x%0h data=0x%0h cyc=%0d",
                   act[65:64], act[63:48], act[47:32], act[31:0],
                   expv[65:64], expv[63:48], expv[47:32], expv[31:0]);
        end
      end
      wr_count++;
      last_tgt  = act[65:64];
      last_addr = act[63:48];
      last_data = act[47:32];
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int wc;
    int nd;
    logic [7:0] cmd;

    // reset with nwr toggling
    do_reset(4, 1'b1);
    @(negedge clk);
    check("reset strobes", {29'd0, chrowbuf_wr, palette_wr, fontmem_wr}, 32'h7);
    check("reset chrow addr/data", {8'(chrowbuf_wr_addr), chrowbuf_wr_data}, 32'h0);
    check("reset pal addr/data", {8'(palette_wr_addr), palette_wr_data}, 32'h0);
    check("reset font addr/data", {12'(fontmem_wr_addr), fontmem_wr_data}, 32'h0);
    check("reset host_err", 32'(host_err), 32'h0);
    check("reset state", 32'(dut.state_q), 32'(IDLE));

    // palette word
    wc = wr_count;
    host_write(0, 8'h40); host_write(1, 8'h05); host_write(1, 8'h00);
    host_write(1, 8'hF0); host_write(1, 8'h0F);
    settle();
    check("pal write count", 32'(wr_count - wc), 32'd1);
    check("pal addr", 32'(last_addr), 32'h05);
    check("pal data", 32'(last_data), 32'h0FF0);
    check("pal target", 32'(last_tgt), 32'(TGT_PAL));
    check_model("pal");

    // fontmem burst across the address wrap
    wc = wr_count;
    host_write(0, 8'h80); host_write(1, 8'hFF); host_write(1, 8'h0F);
    host_write(1, 8'hAA); host_write(1, 8'h55);
    settle();
    check("font write count", 32'(wr_count - wc), 32'd2);
    check("font wrap addr", 32'(last_addr), 32'h000);
    check("font wrap data", 32'(last_data), 32'h55);
    check_model("font");

    // chrowbuf half word aborted by a new command
    wc = wr_count;
    host_write(0, 8'h00); host_write(1, 8'h10); host_write(1, 8'h00);
    host_write(1, 8'h41); host_write(0, 8'h00);
    settle();
    check("abort write count", 32'(wr_count - wc), 32'd0);
    check("abort state", 32'(dut.state_q), 32'(ADDR_LO));
    check("abort host_err", 32'(host_err), 32'h0);

    // protocol errors
    do_reset(2, 1'b0);
    wc = wr_count;
    host_write(1, 8'h33);
    settle();
    check("stray data host_err", 32'(host_err), 32'h1);
    check("stray data state", 32'(dut.state_q), 32'(IDLE));
    host_write(0, 8'hC0);
    settle();
    check("reserved host_err", 32'(host_err), 32'h1);
    check("reserved state", 32'(dut.state_q), 32'(IDLE));
    check("error write count", 32'(wr_count - wc), 32'd0);

    // reset between the two halves of a word
    do_reset(2, 1'b0);
    host_write(0, 8'h00); host_write(1, 8'h20); host_write(1, 8'h00); host_write(1, 8'h11);
    settle();
    check("midword state", 32'(dut.state_q), 32'(DATA_HI));
    wc = wr_count;
    do_reset(1, 1'b0);
    host_write(1, 8'h22);
    settle();
    check("midword write count", 32'(wr_count - wc), 32'd0);
    check("midword host_err", 32'(host_err), 32'h1);
    check("midword state after", 32'(dut.state_q), 32'(IDLE));

    // randomized sequences against the model
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 3), 1'b0);
      cmd = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) != 0) cmd[7:6] = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) != 0) host_write(0, cmd);
      nd = $urandom_range(0, 8);
      for (int j = 0; j < nd; j++) begin
        if (j == 1 && $urandom_range(0, 1) == 1) host_write(1, 8'hFF);
        else if (j == 0 && $urandom_range(0, 2) == 0) host_write(1, 8'hFE);
        else host_write(1, 8'($urandom_range(0, 255)));
      end
      settle();
      check_model($sformatf("random %0d", it));
    end

    settle();
    check("pending writes", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
